// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and constants for the EX-stage branch redirect controller.
package branch_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    KIND_NONE   = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_JAL    = 2'd2,
    KIND_JALR   = 2'd3
  } kind_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// EX-stage resolve inputs and fetch redirect / flush outputs of the redirect controller.
interface branch_redirect_ctrl_if #(
  parameter int unsigned CNT_W = 16
);

  logic             EX_VALID;
  logic [1:0]       EX_KIND;
  logic [2:0]       EX_FUNCT3;
  logic             BR_EQ;
  logic             BR_LT;
  logic             BR_LTU;
  logic [31:0]      JAL;
  logic [31:0]      JALR;
  logic [31:0]      BRANCH;
  logic             IF_READY;
  logic             REDIRECT_VALID;
  logic [31:0]      REDIRECT_ADDR;
  logic             FLUSH_IFID;
  logic             FLUSH_IDEX;
  logic             MISALIGN;
  logic [CNT_W-1:0] TAKEN_CNT;
  logic [CNT_W-1:0] NOT_TAKEN_CNT;

  modport master (
    output EX_VALID, EX_KIND, EX_FUNCT3, BR_EQ, BR_LT, BR_LTU, JAL, JALR, BRANCH, IF_READY,
    input  REDIRECT_VALID, REDIRECT_ADDR, FLUSH_IFID, FLUSH_IDEX, MISALIGN, TAKEN_CNT,
           NOT_TAKEN_CNT
  );

  modport slave (
    input  EX_VALID, EX_KIND, EX_FUNCT3, BR_EQ, BR_LT, BR_LTU, JAL, JALR, BRANCH, IF_READY,
    output REDIRECT_VALID, REDIRECT_ADDR, FLUSH_IFID, FLUSH_IDEX, MISALIGN, TAKEN_CNT,
           NOT_TAKEN_CNT
  );

endinterface

// File: rtl/branch_redirect_ctrl_cond.sv
// Conditional-branch outcome from funct3 and the comparator flags.
module branch_redirect_ctrl_cond
  import branch_redirect_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       br_eq,
  input  logic       br_lt,
  input  logic       br_ltu,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    unique case (funct3)
      F3_BEQ:  taken = br_eq;
      F3_BNE:  taken = ~br_eq;
      F3_BLT:  taken = br_lt;
      F3_BGE:  taken = ~br_lt;
      F3_BLTU: taken = br_ltu;
      F3_BGEU: taken = ~br_ltu;
      default: taken = 1'b0; // 010/011 are not branches
    endcase
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Control-hazard sequencer: resolves EX branches/jumps, drives PC redirect and flushes,
// holds the redirect while fetch stalls, and counts taken/not-taken outcomes.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic                   CLK,
  input logic                   RST,
  branch_redirect_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [0:0]       state_q, state_d;
  logic [31:0]      pend_addr_q, pend_addr_d;
  logic [CNT_W-1:0] taken_cnt_q, not_taken_cnt_q;

  kind_e       kind;
  logic        br_taken;
  logic        taken;
  logic [31:0] target;
  logic        aligned;
  logic        resolve;

  assign kind = kind_e'(bus.EX_KIND);

  branch_redirect_ctrl_cond u_cond (
    .funct3 (bus.EX_FUNCT3),
    .br_eq  (bus.BR_EQ),
    .br_lt  (bus.BR_LT),
    .br_ltu (bus.BR_LTU),
    .taken  (br_taken)
  );

  always_comb begin
    target = 32'd0;
    taken  = 1'b0;
    unique case (kind)
      KIND_BRANCH: begin
        target = bus.BRANCH;
        taken  = br_taken;
      end
      KIND_JAL: begin
        target = bus.JAL;
        taken  = 1'b1;
      end
      KIND_JALR: begin
        target = bus.JALR & ~32'd1;
        taken  = 1'b1;
      end
      default: begin
        target = 32'd0;
        taken  = 1'b0;
      end
    endcase
  end

  assign aligned = (target[1:0] == 2'b00);
  assign resolve = bus.EX_VALID && (kind != KIND_NONE) && (state_q == ST_IDLE);

  // Outputs are forced low while RST is high, even though they are combinational.
  always_comb begin
    state_d            = state_q;
    pend_addr_d        = pend_addr_q;
    bus.REDIRECT_VALID = 1'b0;
    bus.REDIRECT_ADDR  = 32'd0;
    bus.FLUSH_IFID     = 1'b0;
    bus.FLUSH_IDEX     = 1'b0;
    bus.MISALIGN       = 1'b0;
    if (!RST) begin
      if (state_q == ST_PENDING) begin
        bus.REDIRECT_VALID = 1'b1;
        bus.REDIRECT_ADDR  = pend_addr_q;
        bus.FLUSH_IFID     = 1'b1;
        bus.FLUSH_IDEX     = 1'b1;
        if (bus.IF_READY) state_d = ST_IDLE;
      end else if (resolve && taken) begin
        if (!aligned) begin
          bus.MISALIGN = 1'b1;
        end else begin
          bus.FLUSH_IFID = 1'b1;
          bus.FLUSH_IDEX = 1'b1;
          if (bus.IF_READY) begin
            bus.REDIRECT_VALID = 1'b1;
            bus.REDIRECT_ADDR  = target;
          end else begin
            state_d     = ST_PENDING;
            pend_addr_d = target;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      pend_addr_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      taken_cnt_q     <= '0;
      not_taken_cnt_q <= '0;
    end else if (resolve) begin
      if (taken) begin
        if (taken_cnt_q != CntMax) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
      end else begin
        if (not_taken_cnt_q != CntMax) not_taken_cnt_q <= not_taken_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.TAKEN_CNT     = taken_cnt_q;
  assign bus.NOT_TAKEN_CNT = not_taken_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: default-width instance plus a CNT_W=2 instance
// sharing the same stimulus for the saturation check.
module tb_branch_redirect_ctrl;
  import branch_redirect_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  branch_redirect_ctrl_if #(.CNT_W(16)) bus ();
  branch_redirect_ctrl_if #(.CNT_W(2))  bus2 ();

  branch_redirect_ctrl #(.CNT_W(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  branch_redirect_ctrl #(.CNT_W(2)) dut2 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus2.slave)
  );

  assign bus2.EX_VALID  = bus.EX_VALID;
  assign bus2.EX_KIND   = bus.EX_KIND;
  assign bus2.EX_FUNCT3 = bus.EX_FUNCT3;
  assign bus2.BR_EQ     = bus.BR_EQ;
  assign bus2.BR_LT     = bus.BR_LT;
  assign bus2.BR_LTU    = bus.BR_LTU;
  assign bus2.JAL       = bus.JAL;
  assign bus2.JALR      = bus.JALR;
  assign bus2.BRANCH    = bus.BRANCH;
  assign bus2.IF_READY  = bus.IF_READY;

  always #5 CLK = ~CLK;

  // Stimulus must never present a valid EX instruction while a redirect is pending.
  always @(negedge CLK) begin
    if (!RST && dut.state_q == ST_PENDING && bus.EX_VALID) begin
      miscompares++;
      $error("FAIL ex_valid_in_pending observed=1 expected=0");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rv, input logic [31:0] addr,
                         input logic fl, input logic mis);
    chk({tag, ".redirect_valid"}, {31'd0, bus.REDIRECT_VALID}, {31'd0, rv});
    chk({tag, ".redirect_addr"}, bus.REDIRECT_ADDR, addr);
    chk({tag, ".flush_ifid"}, {31'd0, bus.FLUSH_IFID}, {31'd0, fl});
    chk({tag, ".flush_idex"}, {31'd0, bus.FLUSH_IDEX}, {31'd0, fl});
    chk({tag, ".misalign"}, {31'd0, bus.MISALIGN}, {31'd0, mis});
  endtask

  task automatic chk_cnt(input string tag, input int t, input int nt);
    chk({tag, ".taken_cnt"}, {16'd0, bus.TAKEN_CNT}, t);
    chk({tag, ".not_taken_cnt"}, {16'd0, bus.NOT_TAKEN_CNT}, nt);
  endtask

  // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input kind_e k, input logic [2:0] f3, input logic eq,
                       input logic lt, input logic ltu, input logic rdy);
    bus.EX_VALID  = v;
    bus.EX_KIND   = k;
    bus.EX_FUNCT3 = f3;
    bus.BR_EQ     = eq;
    bus.BR_LT     = lt;
    bus.BR_LTU    = ltu;
    bus.IF_READY  = rdy;
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, KIND_NONE, 3'b000, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    bus.JAL    = 32'h0000_0080;
    bus.JALR   = 32'd0;
    bus.BRANCH = 32'h0000_0100;

    // Reset with an aligned, ready JAL presented: outputs must stay low.
    drive(1'b1, KIND_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_out("reset", 1'b0, 32'd0, 1'b0, 1'b0);
    chk_cnt("reset", 0, 0);
    tick();
    tick();
    RST = 1'b0;
    idle(1'b1);
    chk_out("idle", 1'b0, 32'd0, 1'b0, 1'b0);

    // BEQ taken, fetch ready: same-cycle redirect.
    tick();
    drive(1'b1, KIND_BRANCH, F3_BEQ, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_out("beq", 1'b1, 32'h100, 1'b1, 1'b0);
    tick();
    idle(1'b1);
    chk_out("beq_after", 1'b0, 32'd0, 1'b0, 1'b0);
    chk_cnt("beq_after", 1, 0);

    // BNE with equal operands: not taken.
    drive(1'b1, KIND_BRANCH, F3_BNE, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_out("bne", 1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    idle(1'b1);
    chk_cnt("bne_after", 1, 1);

    // funct3 010 is never taken whatever the flags say.
    drive(1'b1, KIND_BRANCH, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1);
    chk_out("f3_010", 1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    idle(1'b1);
    chk_cnt("f3_010_after", 1, 2);

    // BLT taken to a new target.
    bus.BRANCH = 32'h0000_0204;
    drive(1'b1, KIND_BRANCH, F3_BLT, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_out("blt", 1'b1, 32'h204, 1'b1, 1'b0);
    tick();
    idle(1'b1);
    chk_cnt("blt_after", 2, 2);

    // BGEU with RS1<RS2 unsigned: not taken.
    drive(1'b1, KIND_BRANCH, F3_BGEU, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_out("bgeu", 1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    idle(1'b1);
    chk_cnt("bgeu_after", 2, 3);

    // JALR 0x201 -> 0x200 with fetch stalled 3 cycles; accepted on the 4th.
    bus.JALR = 32'h0000_0201;
    drive(1'b1, KIND_JALR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_out("jalr_c0", 1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    idle(1'b0);
    chk_out("jalr_c1", 1'b1, 32'h200, 1'b1, 1'b0);
    chk_cnt("jalr_c1", 3, 3);
    tick();
    idle(1'b0);
    chk_out("jalr_c2", 1'b1, 32'h200, 1'b1, 1'b0);
    tick();
    idle(1'b1);
    chk_out("jalr_c3", 1'b1, 32'h200, 1'b1, 1'b0);
    tick();
    idle(1'b1);
    chk_out("jalr_done", 1'b0, 32'd0, 1'b0, 1'b0);
    chk_cnt("jalr_done", 3, 3);

    // JAL to 0x102: misaligned, no redirect or flush, still counted taken.
    bus.JAL = 32'h0000_0102;
    drive(1'b1, KIND_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_out("jal_mis", 1'b0, 32'd0, 1'b0, 1'b1);
    tick();
    idle(1'b1);
    chk_out("jal_mis_after", 1'b0, 32'd0, 1'b0, 1'b0);
    chk_cnt("jal_mis_after", 4, 3);

    // JALR 0x203 clears bit 0 to 0x202, which is still misaligned.
    bus.JALR = 32'h0000_0203;
    drive(1'b1, KIND_JALR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_out("jalr_mis", 1'b0, 32'd0, 1'b0, 1'b1);
    tick();
    idle(1'b1);
    chk_cnt("jalr_mis_after", 5, 3);

    // Reset while PENDING discards the redirect immediately.
    bus.JAL = 32'h0000_0300;
    drive(1'b1, KIND_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle(1'b0);
    chk_out("pend", 1'b1, 32'h300, 1'b1, 1'b0);
    RST = 1'b1;
    #1;
    chk_out("pend_rst", 1'b0, 32'd0, 1'b0, 1'b0);
    chk_cnt("pend_rst", 0, 0);
    tick();
    RST = 1'b0;
    idle(1'b0);
    chk_out("post_rst0", 1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    idle(1'b1);
    chk_out("post_rst1", 1'b0, 32'd0, 1'b0, 1'b0);

    // Five back-to-back taken branches: CNT_W=2 saturates at 3.
    bus.BRANCH = 32'h0000_0040;
    for (int i = 0; i < 5; i++) begin
      tick();
      drive(1'b1, KIND_BRANCH, F3_BEQ, 1'b1, 1'b0, 1'b0, 1'b1);
      chk_out("sat_br", 1'b1, 32'h40, 1'b1, 1'b0);
    end
    tick();
    idle(1'b1);
    chk("sat.taken_cnt_w2", {30'd0, bus2.TAKEN_CNT}, 32'd3);
    chk("sat.not_taken_cnt_w2", {30'd0, bus2.NOT_TAKEN_CNT}, 32'd0);
    chk_cnt("sat_w16", 5, 0);
    tick();
    chk("sat_hold.taken_cnt_w2", {30'd0, bus2.TAKEN_CNT}, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
